// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: byte width, drop counter width
// and the launch FSM state encoding.
package uart_tx_fifo_pkg;
  localparam int BYTE_W = 8;
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;
endpackage

// File: rtl/byte_fifo_ram.sv
// DEPTH x BYTE_W storage for the transmit FIFO: synchronous write and an
// asynchronous read, so the head byte is available in the same cycle as a launch.
module byte_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch controller feeding the UART transmitter.
// Optional macro DROP_COUNT_EN adds the saturating drop_count port.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int BUSY_WAIT_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic                   txd_busy,
  output logic                   txd_start,
  output logic [BYTE_W-1:0]      txd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
`ifdef DROP_COUNT_EN
  output logic [DROP_W-1:0]      drop_count,
`endif
  output tx_state_e              fsm_state
);
  // Handshake: wr_valid is a one-cycle strobe with no ready; a strobe seen while
  // full is dropped. txd_start is a one-cycle pulse, acknowledged by txd_busy.
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(BUSY_WAIT_MAX) + 1;

  logic [ADDR_W:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    wait_cnt;
  logic [BYTE_W-1:0]   rd_data;
  logic                wr_accept;
  logic                launch;
  tx_state_e           state, state_d;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign wr_accept = wr_valid && !full;
  assign fsm_state = state;

  byte_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !txd_busy) begin
          launch  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Give up on a transmitter that never acknowledges, so the queue keeps draining.
        if (txd_busy) state_d = WAIT_DONE;
        else if (wait_cnt == CNT_W'(BUSY_WAIT_MAX - 1)) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (!txd_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wait_cnt  <= '0;
      txd_start <= 1'b0;
      txd_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      txd_start <= launch;
      if (launch) begin
        txd_data <= rd_data;
        rd_ptr   <= rd_ptr + (ADDR_W+1)'(1);
        wait_cnt <= '0;
      end else if (state == WAIT_BUSY && !txd_busy) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (wr_accept) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (wr_valid && full) overflow <= 1'b1;
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (wr_valid && full && drop_count != '1) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for the fill/overflow pattern
// plus hand-written sequences for launch timing, timeout, pointer wrap and reset.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int FRAME = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        txd_busy;
  logic        txd_start;
  logic [7:0]  txd_data;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
`ifdef DROP_COUNT_EN
  logic [15:0] drop_count;
`endif
  tx_state_e   fsm_state;

  logic busy_force = 1'b0;
  logic never_busy = 1'b0;
  logic model_busy = 1'b0;
  int   frame_left = 0;

  logic [7:0] got_mem [256];
  int         got_wr = 0;
  int         got_rd = 0;
  logic [7:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign txd_busy = busy_force | model_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_WAIT_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .txd_busy   (txd_busy),
    .txd_start  (txd_start),
    .txd_data   (txd_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
`ifdef DROP_COUNT_EN
    .drop_count (drop_count),
`endif
    .fsm_state  (fsm_state)
  );

  // Transmitter model: captures each launched byte, then stays busy for FRAME cycles.
  always @(posedge clk) begin
    if (txd_start) begin
      got_mem[got_wr[7:0]] <= txd_data;
      got_wr <= got_wr + 1;
      if (!never_busy) begin
        model_busy <= 1'b1;
        frame_left <= FRAME;
      end
    end else if (frame_left != 0) begin
      frame_left <= frame_left - 1;
      if (frame_left == 1) model_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(empty && fsm_state == IDLE && !txd_busy) && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < 1000), 32'd1);
    check({name, "_nbytes"}, 32'(got_wr - got_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_rd < got_wr) begin
      check($sformatf("%s_byte%0d", name, got_rd), 32'(got_mem[got_rd[7:0]]), 32'(exp_q.pop_front()));
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_wr;
  endtask

  typedef struct {
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       busy;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
    logic       exp_start;
  } vec_t;

  vec_t vecs [18];

  initial begin
    logic       starts [15];
    logic [7:0] datas  [15];
    tx_state_e  states [15];
    logic       bad;

    // Fill with 0x00..0x0F while busy, then a dropped 17th write, then a quiet cycle.
    for (int i = 0; i < 16; i++) begin
      vecs[i].wr_valid  = 1'b1;
      vecs[i].wr_data   = 8'(i);
      vecs[i].busy      = 1'b1;
      vecs[i].exp_count = 5'(i + 1);
      vecs[i].exp_full  = (i == 15);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_ovf   = 1'b0;
      vecs[i].exp_start = 1'b0;
    end
    vecs[16] = '{wr_valid: 1'b1, wr_data: 8'hEE, busy: 1'b1, exp_count: 5'd16,
                 exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b1, exp_start: 1'b0};
    vecs[17] = '{wr_valid: 1'b0, wr_data: 8'h00, busy: 1'b1, exp_count: 5'd16,
                 exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b1, exp_start: 1'b0};

    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (3) tick();
    check("rst_start", 32'(txd_start), 32'd0);
    check("rst_data", 32'(txd_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
`ifdef DROP_COUNT_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    reset = 1'b1;
    tick();

    // Single byte into an idle transmitter: launch two edges after the strobe.
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_valid = 1'b0;
    check("a5_count1", 32'(count), 32'd1);
    check("a5_nostart", 32'(txd_start), 32'd0);
    tick();
    check("a5_start", 32'(txd_start), 32'd1);
    check("a5_data", 32'(txd_data), 32'hA5);
    check("a5_count0", 32'(count), 32'd0);
    tick();
    check("a5_pulse_end", 32'(txd_start), 32'd0);
    exp_q.push_back(8'hA5);
    wait_drain("a5");

    // Table-driven fill and overflow.
    for (int v = 0; v < 18; v++) begin
      busy_force = vecs[v].busy;
      wr_valid   = vecs[v].wr_valid;
      wr_data    = vecs[v].wr_data;
      tick();
      check($sformatf("fill%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
      check($sformatf("fill%0d_full", v), 32'(full), 32'(vecs[v].exp_full));
      check($sformatf("fill%0d_empty", v), 32'(empty), 32'(vecs[v].exp_empty));
      check($sformatf("fill%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
      check($sformatf("fill%0d_start", v), 32'(txd_start), 32'(vecs[v].exp_start));
    end
    wr_valid = 1'b0;
`ifdef DROP_COUNT_EN
    check("fill_drop", 32'(drop_count), 32'd1);
`endif
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    busy_force = 1'b0;
    wait_drain("fill");
    check("fill_ovf_sticky", 32'(overflow), 32'd1);

    // Transmitter that never goes busy: launches every 5 edges via the timeout.
    never_busy = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      wr_valid = (e <= 3);
      wr_data  = 8'(8'h30 + e);
      tick();
      starts[e] = txd_start;
      datas[e]  = txd_data;
      states[e] = fsm_state;
    end
    wr_valid = 1'b0;
    for (int e = 1; e <= 14; e++)
      check($sformatf("nb_start_e%0d", e), 32'(starts[e]), 32'(e == 2 || e == 7 || e == 12));
    check("nb_data0", 32'(datas[2]), 32'h31);
    check("nb_data1", 32'(datas[7]), 32'h32);
    check("nb_data2", 32'(datas[12]), 32'h33);
    check("nb_state_e5", 32'(states[5]), 32'(WAIT_BUSY));
    check("nb_state_e6", 32'(states[6]), 32'(IDLE));
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    exp_q.push_back(8'h33);
    wait_drain("nb");
    never_busy = 1'b0;

    // Move pointers to entry 13 (20 writes so far + 9).
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write_byte(8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
    end
    busy_force = 1'b0;
    wait_drain("adv");

    // Entries 13,14,15 queued; then write (into entry 0) and launch in the same cycle.
    busy_force = 1'b1;
    write_byte(8'h51);
    write_byte(8'h52);
    write_byte(8'h53);
    check("wrap_count3", 32'(count), 32'd3);
    busy_force = 1'b0;
    wr_valid   = 1'b1;
    wr_data    = 8'h7C;
    tick();
    wr_valid = 1'b0;
    check("wrap_start", 32'(txd_start), 32'd1);
    check("wrap_data", 32'(txd_data), 32'h51);
    check("wrap_count_same", 32'(count), 32'd3);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h7C);
    wait_drain("wrap");

    // Reset with five bytes queued and the transmitter busy.
    busy_force = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
    check("mid_count5", 32'(count), 32'd5);
    reset = 1'b0;
    tick();
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_ovf", 32'(overflow), 32'd0);
    check("mid_start", 32'(txd_start), 32'd0);
    check("mid_state", 32'(fsm_state), 32'(IDLE));
`ifdef DROP_COUNT_EN
    check("mid_drop", 32'(drop_count), 32'd0);
`endif
    reset = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (txd_start) bad = 1'b1;
    end
    busy_force = 1'b0;
    repeat (4) begin
      tick();
      if (txd_start) bad = 1'b1;
    end
    check("mid_no_launch", 32'(bad), 32'd0);
    write_byte(8'h99);
    tick();
    check("mid_relaunch", 32'(txd_start), 32'd1);
    check("mid_relaunch_data", 32'(txd_data), 32'h99);
    exp_q.push_back(8'h99);
    wait_drain("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
